// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: 2-flop sync, per-channel debounce FSM, press/release pulses.
// Optional auto-repeat of btn_press while held, enabled by defining BTN_REPEAT_EN.
module btn_conditioner #(
  parameter int NUM_BTN       = 4,
  parameter int DEB_CYCLES    = 512,
  parameter int REPEAT_DELAY  = 5_000_000,
  parameter int REPEAT_PERIOD = 2_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_press
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  if (DEB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("btn_conditioner: illegal parameter value");
  end

  logic [NUM_BTN-1:0] sync1, sync2;

  // Synchronizer is cleared only by reset; en does not stop it sampling.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  assign any_press = |btn_press;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic          level_r, press_r, release_r;
    logic          in_s;

    assign in_s           = sync2[i];
    assign btn_level[i]   = level_r;
    assign btn_press[i]   = press_r;
    assign btn_release[i] = release_r;

`ifdef BTN_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    logic [RW-1:0] rcnt;
    logic          rfirst;
    logic          rfire;

    // First repeat waits REPEAT_DELAY held cycles, later ones REPEAT_PERIOD.
    always_comb begin
      rfire = 1'b0;
      if (rfirst) rfire = (rcnt == RW'(REPEAT_DELAY - 1));
      else        rfire = (rcnt == RW'(REPEAT_PERIOD - 1));
    end
`endif

    always_ff @(posedge clk) begin
      if (reset || !en) begin
        state     <= IDLE;
        cnt       <= '0;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
`ifdef BTN_REPEAT_EN
        rcnt      <= '0;
        rfirst    <= 1'b1;
`endif
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        case (state)
          IDLE: begin
            if (in_s) begin
              state <= PRESS_WAIT;
              cnt   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!in_s) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state   <= HELD;
              cnt     <= '0;
              level_r <= 1'b1;
              press_r <= 1'b1;
`ifdef BTN_REPEAT_EN
              rcnt    <= '0;
              rfirst  <= 1'b1;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HELD: begin
            if (!in_s) begin
              state <= RELEASE_WAIT;
              cnt   <= '0;
            end
`ifdef BTN_REPEAT_EN
            else if (rfire) begin
              press_r <= 1'b1;
              rcnt    <= '0;
              rfirst  <= 1'b0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
`endif
          end
          RELEASE_WAIT: begin
            // Repeat counter is deliberately untouched here so it resumes on return to HELD.
            if (in_s) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state     <= IDLE;
              cnt       <= '0;
              level_r   <= 1'b0;
              release_r <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomized + directed bench for btn_conditioner against a run-length reference model.
module tb_btn_conditioner;
  localparam int NB   = 4;
  localparam int DEB  = 8;
  localparam int RDLY = 20;
  localparam int RPER = 5;

  logic          clk = 1'b0;
  logic          reset, en;
  logic [NB-1:0] btn_in, btn_level, btn_press, btn_release;
  logic          any_press;

  btn_conditioner #(
    .NUM_BTN(NB), .DEB_CYCLES(DEB), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .any_press(any_press)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: debounced level flips once the synced input has differed from it
  // for DEB+1 consecutive samples; held-cycle count drives auto-repeat.
  bit m_s1[NB], m_s2[NB], m_level[NB];
  int m_run[NB], m_hcnt[NB];
  logic [NB-1:0] exp_level, exp_press, exp_rel;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_edge();
    for (int ch = 0; ch < NB; ch++) begin
      bit s;
      s = m_s2[ch];
      exp_press[ch] = 1'b0;
      exp_rel[ch]   = 1'b0;
      if (reset) begin
        m_s1[ch] = 0; m_s2[ch] = 0; m_level[ch] = 0; m_run[ch] = 0; m_hcnt[ch] = 0;
      end else begin
        m_s2[ch] = m_s1[ch];
        m_s1[ch] = btn_in[ch];
        if (!en) begin
          m_level[ch] = 0;
          m_run[ch]   = 0;
        end else if (s == m_level[ch]) begin
          if (m_level[ch] && m_run[ch] == 0) begin
            m_hcnt[ch]++;
`ifdef BTN_REPEAT_EN
            if (m_hcnt[ch] == RDLY || (m_hcnt[ch] > RDLY && (m_hcnt[ch] - RDLY) % RPER == 0))
              exp_press[ch] = 1'b1;
`endif
          end
          m_run[ch] = 0;
        end else begin
          m_run[ch]++;
          if (m_run[ch] == DEB + 1) begin
            m_level[ch]   = s;
            m_run[ch]     = 0;
            m_hcnt[ch]    = 0;
            exp_press[ch] = s;
            exp_rel[ch]   = !s;
          end
        end
      end
      exp_level[ch] = m_level[ch];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("level",   btn_level,   exp_level);
    check_eq("press",   btn_press,   exp_press);
    check_eq("release", btn_release, exp_rel);
    check_eq("any",     any_press,   |exp_press);
  endtask

  initial begin
    int first0, first1, cnt1, cnt2, rel_cnt, cntany;
    int hold[NB];
    reset = 1'b1; en = 1'b1; btn_in = '0;
    repeat (3) step();
    check_eq("reset_level", btn_level, 0);
    reset = 1'b0;

    // Clean press ch0, bounce ch1, long hold ch2.
    first0 = -1; first1 = -1; cnt1 = 0; cnt2 = 0;
    for (int k = 0; k < 50; k++) begin
      btn_in = {1'b0, 1'b1, (k != 5), 1'b1};
      step();
      if (btn_press[0] && first0 < 0) first0 = k;
      if (btn_press[1] && first1 < 0) first1 = k;
      if (btn_press[1]) cnt1++;
      if (btn_press[2]) cnt2++;
      if (k == 10) check_eq("level0_at10", btn_level[0], 1);
    end
    check_eq("press0_edge", first0, 10);
    check_eq("bounce1_edge", first1, 16);
    check_eq("bounce1_count", cnt1, 1);
`ifdef BTN_REPEAT_EN
    check_eq("repeat2_count", cnt2, 5);
`else
    check_eq("repeat2_count", cnt2, 1);
`endif

    // Short low glitch while held: no release.
    rel_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      btn_in = (k < 3) ? 4'b0000 : 4'b0111;
      step();
      if (btn_release != 0) rel_cnt++;
    end
    check_eq("glitch_release", rel_cnt, 0);

    // Clean release.
    first0 = -1;
    for (int k = 0; k < 30; k++) begin
      btn_in = '0;
      step();
      if (btn_release[0] && first0 < 0) first0 = k;
      if (k == 9)  check_eq("level0_before_rel", btn_level[0], 1);
      if (k == 10) check_eq("level0_after_rel", btn_level[0], 0);
    end
    check_eq("release0_edge", first0, 10);

    // Reset mid-qualification on ch3.
    first0 = -1;
    for (int k = 0; k < 30; k++) begin
      btn_in = 4'b1000;
      reset  = (k == 5);
      step();
      if (btn_press[3] && first0 < 0) first0 = k;
    end
    reset = 1'b0;
    check_eq("reset_press_edge", first0, 16);

    // en low while held: level drops, no release.
    en = 1'b0;
    step();
    check_eq("en_level", btn_level[3], 0);
    check_eq("en_release", btn_release[3], 0);
    en = 1'b1;
    repeat (20) step();

    // Simultaneous press on all channels.
    btn_in = '0;
    repeat (30) step();
    cntany = 0;
    for (int k = 0; k < 25; k++) begin
      btn_in = '1;
      step();
      if (any_press) cntany++;
      if (k == 10) check_eq("all_press", btn_press, 4'hF);
    end
    check_eq("any_once", cntany, 1);

    // Randomized segments.
    for (int ch = 0; ch < NB; ch++) hold[ch] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int ch = 0; ch < NB; ch++) begin
        if (hold[ch] == 0) begin
          btn_in[ch] = 1'($urandom_range(0, 1));
          hold[ch]   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                  : int'($urandom_range(5, 40));
        end
        hold[ch]--;
      end
      en    = ($urandom_range(0, 199) != 0);
      reset = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
